// File: rtl/sram_mem_controller_pkg.sv
// rtl/sram_mem_controller_pkg.sv - shared state enum and default parameters for the SRAM controller
package sram_mem_controller_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_LO = 2'd1,
        ACC_HI = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int          DEF_DATA_W      = 32;
    localparam int          DEF_SRAM_ADDR_W = 18;
    localparam int          DEF_SRAM_DATA_W = 16;
    localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;
    localparam int          DEF_WAIT_CYCLES = 4;

endpackage

// File: rtl/sram_wait_counter.sv
// rtl/sram_wait_counter.sv - per-half-word wait counter, flags the last count of an access
module sram_wait_counter
    import sram_mem_controller_pkg::*;
#(
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic last_o
);

    localparam int             CNT_W    = $clog2(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(WAIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign last_o = (cnt_q == LAST_VAL);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = last_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sram_mem_controller.sv
// rtl/sram_mem_controller.sv - MEM-stage responder running 32-bit accesses as two 16-bit async SRAM transfers; optional SRAM_LAST_WRITE_FWD_EN
module sram_mem_controller
    import sram_mem_controller_pkg::*;
#(
    parameter int          DATA_W      = DEF_DATA_W,
    parameter int          SRAM_ADDR_W = DEF_SRAM_ADDR_W,
    parameter int          SRAM_DATA_W = DEF_SRAM_DATA_W,
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [31:0]            address,
    input  logic [DATA_W-1:0]      wdata,
    output logic [DATA_W-1:0]      rdata,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N
);

    localparam int IDX_W = SRAM_ADDR_W - 1;

    state_e                 state_q, state_d;
    logic                   op_wr_q, op_wr_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic [SRAM_DATA_W-1:0] rd_lo_q, rd_lo_d;

    logic                   req;
    logic                   in_acc;
    logic                   cnt_last, cnt_clear, cnt_en;
    logic [31:0]            offset;
    logic [IDX_W-1:0]       req_idx;
    logic [SRAM_DATA_W-1:0] dq_out;
    logic                   unused_addr_bits;

    assign req              = mem_read | mem_write;
    assign offset           = address - BASE_ADDR;
    assign req_idx          = offset[IDX_W+1:2];
    assign unused_addr_bits = ^{offset[31:IDX_W+2], offset[1:0]};

`ifdef SRAM_LAST_WRITE_FWD_EN
    logic              fwd_valid_q, fwd_valid_d;
    logic [IDX_W-1:0]  fwd_idx_q, fwd_idx_d;
    logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    assign fwd_hit  = mem_read && !mem_write && fwd_valid_q && (fwd_idx_q == req_idx);
    assign fwd_data = fwd_data_q;

    // Entry is refreshed only when the high half of a write has fully completed.
    always_comb begin
        fwd_valid_d = fwd_valid_q;
        fwd_idx_d   = fwd_idx_q;
        fwd_data_d  = fwd_data_q;
        if (state_q == ACC_HI && cnt_last && op_wr_q) begin
            fwd_valid_d = 1'b1;
            fwd_idx_d   = idx_q;
            fwd_data_d  = wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fwd_valid_q <= 1'b0;
            fwd_idx_q   <= '0;
            fwd_data_q  <= '0;
        end else begin
            fwd_valid_q <= fwd_valid_d;
            fwd_idx_q   <= fwd_idx_d;
            fwd_data_q  <= fwd_data_d;
        end
    end
`else
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear_i(cnt_clear),
        .en_i   (cnt_en),
        .last_o (cnt_last)
    );

    always_comb begin
        state_d   = state_q;
        op_wr_d   = op_wr_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        rd_lo_d   = rd_lo_q;
        ready     = 1'b0;
        cnt_en    = 1'b0;
        cnt_clear = 1'b0;
        case (state_q)
            IDLE: begin
                ready     = !req;
                cnt_clear = 1'b1;
                if (req) begin
                    op_wr_d = mem_write;
                    idx_d   = req_idx;
                    wdata_d = wdata;
                    if (fwd_hit) begin
                        rdata_d = fwd_data;
                        state_d = DONE;
                    end else begin
                        state_d = ACC_LO;
                    end
                end
            end
            ACC_LO: begin
                cnt_en = 1'b1;
                if (cnt_last) begin
                    if (!op_wr_q) begin
                        rd_lo_d = SRAM_DQ;
                    end
                    state_d = ACC_HI;
                end
            end
            ACC_HI: begin
                cnt_en = 1'b1;
                if (cnt_last) begin
                    if (!op_wr_q) begin
                        rdata_d = {SRAM_DQ, rd_lo_q};
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                ready     = 1'b1;
                cnt_clear = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rd_lo_q <= '0;
        end else begin
            state_q <= state_d;
            op_wr_q <= op_wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rd_lo_q <= rd_lo_d;
        end
    end

    // WE_N rises on the last count while address and data stay put, giving hold time.
    assign in_acc    = (state_q == ACC_LO) || (state_q == ACC_HI);
    assign SRAM_ADDR = in_acc ? {idx_q, (state_q == ACC_HI)} : '0;
    assign SRAM_WE_N = !(in_acc && op_wr_q && !cnt_last);
    assign SRAM_OE_N = !(in_acc && !op_wr_q);
    assign dq_out    = (state_q == ACC_HI) ? wdata_q[DATA_W-1:SRAM_DATA_W] : wdata_q[SRAM_DATA_W-1:0];
    assign SRAM_DQ   = (in_acc && op_wr_q) ? dq_out : 'z;
    assign rdata     = rdata_q;

endmodule
